qspi_sram_target: RTL
=====================

QSPI_SRAM_TARGET -- requirements
Module: qspi_sram_target

Interface
REQ-001 Parameters SHALL be: DATA_BUS_WIDTH, default 8, byte width; ADDRESS_WIDTH, default 16, address width; DUMMY_CYCLES, default 4, SCK cycles between address and read data.
REQ-002 Ports SHALL be listed as below, clock and reset first.
- clock  input  1  single system clock; all flops use it.
- reset  input  1  asynchronous, active-low reset.
- spi_clk_in  input  1  QSPI SCK from the initiator, mode 0; clock SHALL be >= 4x SCK.
- spi_select  input  1  chip select, active-low.
- spi_data_in  input  4  IO[3:0] from the initiator.
- spi_data_out  output  4  IO[3:0] driven to the initiator.
- spi_data_oe  output  4  per-IO output enable, 1 = drive.
- mem_addr  output  ADDRESS_WIDTH  backing-store byte address.
- mem_wdata  output  DATA_BUS_WIDTH  backing-store write byte.
- mem_we  output  1  one-cycle write strobe.
- mem_re  output  1  one-cycle read strobe; mem_rdata is valid on the next clock.
- mem_rdata  input  DATA_BUS_WIDTH  backing-store read byte.
- busy  output  1  high while a transaction is selected.

Function
REQ-003 spi_clk_in, spi_select and spi_data_in SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized SCK.
REQ-004 Input nibbles SHALL be sampled on synchronized SCK rising edges, high nibble first; output nibbles SHALL change only on synchronized SCK falling edges.
REQ-005 The state machine SHALL have states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE.
REQ-006 IDLE -> CMD SHALL occur on the synchronized select falling edge.
REQ-007 CMD SHALL take 2 nibbles; 0xEB -> ADDR(read), 0x38 -> ADDR(write), any other value -> IGNORE.
REQ-008 ADDR SHALL take ADDRESS_WIDTH/4 nibbles, MSB first; it then goes to DUMMY (read) or WDATA (write).
REQ-009 DUMMY SHALL last DUMMY_CYCLES rising edges. mem_re SHALL pulse one clock after address completion, and mem_rdata SHALL be captured into the output shift register on the following clock.
REQ-010 RDATA: spi_data_oe SHALL be 4'hF. The first high nibble SHALL be driven on the falling edge after the last dummy rising edge. The next byte SHALL be prefetched (mem_re) when its predecessor's high nibble is driven.
REQ-011 WDATA: each completed byte SHALL produce one mem_we pulse with the current mem_addr and the assembled mem_wdata; an incomplete trailing nibble SHALL be discarded.
REQ-012 mem_addr SHALL increment by 1 after each byte, wrapping from 2^ADDRESS_WIDTH-1 to 0.
REQ-013 spi_data_oe SHALL be 0 in every state except RDATA.
REQ-014 A synchronized select rising edge in any state SHALL return to IDLE on the next clock, with spi_data_oe=0 and no further mem_we/mem_re; a pending partial byte SHALL be dropped.
REQ-015 IGNORE SHALL drive nothing and issue no memory strobes until select deasserts.
REQ-016 mem_we and mem_re SHALL never be high in the same cycle; each SHALL be at most one clock wide per byte.
REQ-017 busy SHALL be high in every state except IDLE.

Reset
REQ-018 While reset=0, all state SHALL clear asynchronously: state=IDLE, spi_data_out=0, spi_data_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0; the synchronizers SHALL clear to select=1, SCK=0.
REQ-019 Reset asserted mid-transaction SHALL abort it, with no trailing write. After release, the block SHALL wait for a fresh select falling edge.

Structure
REQ-020 The state enum qspi_target_state_e and the command constants CMD_QUAD_READ=0xEB and CMD_QUAD_WRITE=0x38 SHALL live in the shared package alongside the existing *_op_e/*_sel_e types.
REQ-021 The 2-flop synchronizer SHALL be one sub-module, qspi_sync, instantiated for SCK, select and data.

Verification
REQ-022 Write 0x38, addr 0x1234, data 0xA5 0x5A -> mem_we at 0x1234=0xA5 and 0x1235=0x5A, exactly 2 pulses.
REQ-023 Read 0xEB, addr 0x0040, 4 dummy cycles, memory holds 0x3C,0xC3 -> IO shows nibbles 3,C,C,3 and oe=F only during the data phase.
REQ-024 Write at 0xFFFF with 2 bytes -> writes at 0xFFFF then 0x0000.
REQ-025 Command 0x9F followed by 8 nibbles -> no strobes, oe stays 0, busy falls within 3 clocks of select deassertion.
REQ-026 Write 0x38, addr 0x0010, 3 nibbles then select high -> one mem_we (byte 0 only); oe=0 within 3 clocks.
REQ-027 reset=0 during a read data phase -> oe=0 immediately; after release, a new read of 0x0040 returns correct data.

Source files
------------

// File: rtl/qspi_sram_target_pkg.sv
// -----------------------------------------------------------------------------
// qspi_sram_target_pkg
// Shared types and constants for the QSPI SRAM target.
//   qspi_target_state_e : transaction state machine encoding
//   qspi_op_e           : decoded transaction type from the command byte
//   qspi_oe_sel_e       : IO output-enable patterns
//   CMD_QUAD_READ/WRITE : supported command opcodes
//   cmd_to_op()         : command byte -> qspi_op_e
// -----------------------------------------------------------------------------
package qspi_sram_target_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } qspi_target_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } qspi_op_e;

  typedef enum logic [3:0] {
    OE_RELEASE = 4'h0,
    OE_QUAD    = 4'hF
  } qspi_oe_sel_e;

  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;

  // Unsupported opcodes decode to OP_NONE, which sends the FSM to IGNORE.
  function automatic qspi_op_e cmd_to_op(input logic [7:0] cmd);
    case (cmd)
      CMD_QUAD_READ:  return OP_READ;
      CMD_QUAD_WRITE: return OP_WRITE;
      default:        return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_sram_target_sync.sv
// -----------------------------------------------------------------------------
// qspi_sync
// Two-flop synchronizer bringing an asynchronous bus into the clock domain.
// Ports:
//   clock  : destination clock
//   reset  : asynchronous active-low reset, loads RESET_VALUE into both flops
//   raw    : asynchronous input
//   synced : synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module qspi_sync
  import qspi_sram_target_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= RESET_VALUE;
      synced <= RESET_VALUE;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/qspi_sram_target.sv
// -----------------------------------------------------------------------------
// qspi_sram_target
// QSPI (mode 0, quad IO) target bridging 0xEB quad-read and 0x38 quad-write
// transactions onto a simple synchronous byte-wide backing store.
// Ports:
//   clock, reset        : system clock (>= 4x SCK), async active-low reset
//   spi_clk_in          : SCK from the initiator
//   spi_select          : chip select, active-low
//   spi_data_in         : IO[3:0] from the initiator
//   spi_data_out/_oe    : IO[3:0] driven back, per-IO enable (1 = drive)
//   mem_addr/mem_wdata  : backing-store byte address / write byte
//   mem_we / mem_re     : one-cycle write / read strobes
//   mem_rdata           : read byte, valid the clock after mem_re
//   busy                : high while a transaction is selected
// -----------------------------------------------------------------------------
module qspi_sram_target
  import qspi_sram_target_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DUMMY_CYCLES   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      spi_clk_in,
  input  logic                      spi_select,
  input  logic [3:0]                spi_data_in,
  output logic [3:0]                spi_data_out,
  output logic [3:0]                spi_data_oe,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  output logic                      busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDRESS_WIDTH / 4 - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BUS_WIDTH / 4 - 1);

  logic       sck_s, sel_s;
  logic [3:0] data_s;
  logic       sck_d, sel_d;
  logic [1:0] prime_cnt;
  logic       primed;
  logic       sck_rise, sck_fall, sel_rise, sel_fall;

  qspi_target_state_e state, state_next;
  qspi_op_e           op, op_next;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         cmd_hi;
  logic [DATA_BUS_WIDTH-1:0] rd_shift;
  logic [DATA_BUS_WIDTH-1:0] out_shift;
  logic               fetch_pending, cap_pending;

  logic cnt_clr, cnt_inc, shift_cmd, shift_addr, shift_wr;
  logic emit_write, fetch_req, drive_first, drive_next, abort;

  qspi_sync #(.WIDTH(1), .RESET_VALUE(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .raw(spi_clk_in), .synced(sck_s)
  );

  qspi_sync #(.WIDTH(1), .RESET_VALUE(1'b1)) u_sync_sel (
    .clock(clock), .reset(reset), .raw(spi_select), .synced(sel_s)
  );

  qspi_sync #(.WIDTH(4), .RESET_VALUE(4'h0)) u_sync_data (
    .clock(clock), .reset(reset), .raw(spi_data_in), .synced(data_s)
  );

  // The select synchronizer comes out of reset reading "deselected". If the
  // real select is already low at release, that reset value would look like a
  // falling edge, so select edges are ignored until the pipeline has flushed.
  assign primed   = (prime_cnt == 2'd3);
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign sel_rise =  sel_s & ~sel_d & primed;
  assign sel_fall = ~sel_s &  sel_d & primed;

  assign busy        = (state != IDLE);
  assign spi_data_oe = (state == RDATA) ? OE_QUAD : OE_RELEASE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A deselect outranks everything so no strobe can be
  // requested in the cycle the transaction is being torn down.
  always_comb begin
    state_next  = state;
    op_next     = op;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    shift_cmd   = 1'b0;
    shift_addr  = 1'b0;
    shift_wr    = 1'b0;
    emit_write  = 1'b0;
    fetch_req   = 1'b0;
    drive_first = 1'b0;
    drive_next  = 1'b0;
    abort       = 1'b0;

    if (state != IDLE && sel_rise) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
      abort      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sel_fall) begin
            state_next = CMD;
            cnt_clr    = 1'b1;
          end
        end

        CMD: begin
          if (sck_rise) begin
            if (cnt == '0) begin
              shift_cmd = 1'b1;
              cnt_inc   = 1'b1;
            end else begin
              cnt_clr = 1'b1;
              op_next = cmd_to_op({cmd_hi, data_s});
              case (cmd_to_op({cmd_hi, data_s}))
                OP_READ, OP_WRITE: state_next = ADDR;
                default:           state_next = IGNORE;
              endcase
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            shift_addr = 1'b1;
            if (cnt == ADDR_LAST) begin
              cnt_clr = 1'b1;
              if (op == OP_READ) begin
                state_next = DUMMY;
                fetch_req  = 1'b1;
              end else begin
                state_next = WDATA;
              end
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end

        DUMMY: begin
          if (sck_rise) begin
            if (cnt == DUMMY_LAST) begin
              cnt_clr    = 1'b1;
              state_next = RDATA;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end

        // The first nibble of each byte launches the prefetch of the next
        // one, giving the memory a full byte time before it is needed.
        RDATA: begin
          if (sck_fall) begin
            if (cnt == '0) begin
              drive_first = 1'b1;
              fetch_req   = 1'b1;
            end else begin
              drive_next = 1'b1;
            end
            if (cnt == DATA_LAST) begin
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end

        WDATA: begin
          if (sck_rise) begin
            shift_wr = 1'b1;
            if (cnt == DATA_LAST) begin
              emit_write = 1'b1;
              cnt_clr    = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end

        IGNORE: begin
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Datapath. Address and write data are assembled directly in the output
  // registers: nothing reads them while the nibbles are arriving, and the
  // write strobe lands well before the next nibble can shift in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_d         <= 1'b0;
      sel_d         <= 1'b1;
      prime_cnt     <= 2'd0;
      op            <= OP_NONE;
      cnt           <= '0;
      cmd_hi        <= 4'h0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      fetch_pending <= 1'b0;
      cap_pending   <= 1'b0;
      rd_shift      <= '0;
      out_shift     <= '0;
      spi_data_out  <= 4'h0;
    end else begin
      sck_d <= sck_s;
      sel_d <= sel_s;
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
      end

      op <= op_next;

      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end

      if (shift_cmd) begin
        cmd_hi <= data_s;
      end

      // Increment after a write has been presented, or as soon as a read
      // byte starts shifting out so the prefetch targets the next byte.
      if (shift_addr) begin
        mem_addr <= {mem_addr[ADDRESS_WIDTH-5:0], data_s};
      end else if (mem_we || drive_first) begin
        mem_addr <= mem_addr + 1'b1;
      end

      if (shift_wr) begin
        mem_wdata <= {mem_wdata[DATA_BUS_WIDTH-5:0], data_s};
      end

      mem_we <= emit_write;

      // Read pipeline: request -> mem_re -> memory registers -> capture.
      if (abort) begin
        fetch_pending <= 1'b0;
        cap_pending   <= 1'b0;
        mem_re        <= 1'b0;
        spi_data_out  <= 4'h0;
      end else begin
        fetch_pending <= fetch_req;
        mem_re        <= fetch_pending;
        cap_pending   <= mem_re;
        if (cap_pending) begin
          rd_shift <= mem_rdata;
        end
        if (drive_first) begin
          spi_data_out <= rd_shift[DATA_BUS_WIDTH-1 -: 4];
          out_shift    <= {rd_shift[DATA_BUS_WIDTH-5:0], 4'h0};
        end else if (drive_next) begin
          spi_data_out <= out_shift[DATA_BUS_WIDTH-1 -: 4];
          out_shift    <= {out_shift[DATA_BUS_WIDTH-5:0], 4'h0};
        end
      end
    end
  end

endmodule
